theta_col_parity: RTL and testbench
===================================

THETA_COL_PARITY -- requirements
Module: theta_col_parity

Interface
REQ-001 SHALL have parameter W, default 64, meaning the number of 25-bit slices per state; legal values are 2, 4, 8, 16, 32 and 64.
REQ-002 SHALL have parameter IW, default 6, meaning the slice index width; IW SHALL equal log2(W).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to process one state.
REQ-006 SHALL have port In, input, 25 bits: the slice addressed by page_index, valid in the same cycle (combinational read); bit 5*y+x holds A[x,y].
REQ-007 SHALL have port page_index, output, IW bits: the slice read address.
REQ-008 SHALL have port Ready, output, 1 bit: high when idle and able to accept start.
REQ-009 SHALL have port Out, output, 25 bits: the registered result slice.
REQ-010 SHALL have port out_valid, output, 1 bit: Out and out_index are valid.
REQ-011 SHALL have port out_index, output, IW bits: the slice number z of Out.
REQ-012 SHALL have port parity, output, 5 bits: the registered column parity C[x] of slice out_index.
REQ-013 SHALL have port Done, output, 1 bit: one-cycle completion pulse.

Function
REQ-014 SHALL compute C[x] as the XOR of In[5y+x] over y=0..4, combinationally on the current In.
REQ-015 SHALL compute D[x,z] = C[(x+4)%5,z] ^ C[(x+1)%5,(z-1) mod W], with the slice index wrapping from 0 to W-1.
REQ-016 SHALL use an FSM with states IDLE, PRE and RUN.
REQ-017 IDLE: Ready=1 and page_index=0; start=1 SHALL move the FSM to PRE at the next edge.
REQ-018 PRE: lasts one cycle with page_index=W-1; at the edge, C of slice W-1 SHALL be latched into prev_c and the slice counter z SHALL be cleared to 0; the FSM then moves to RUN.
REQ-019 RUN: page_index=z; each edge SHALL register Out, parity and out_index=z, set out_valid=1, latch C into prev_c and increment z.
REQ-020 RUN SHALL last exactly W cycles; at the edge where z=W-1, the FSM SHALL return to IDLE.
REQ-021 Out SHALL appear with a one-cycle latency after its slice is read.
REQ-022 Done SHALL be a registered pulse, high only in the same cycle as the out_valid of slice W-1.
REQ-023 With start accepted at edge 0, out_valid SHALL be high during cycles 2..W+1, and Ready SHALL be high again in cycle W+1.
REQ-024 start SHALL be ignored outside IDLE.
REQ-025 Holding start high SHALL make the block process states back-to-back, with one IDLE cycle between them.
REQ-026 The z counter SHALL wrap modulo 2^IW without overflow logic.
REQ-027 When out_valid=0, Out, parity and out_index SHALL hold their last values.

Reset
REQ-028 reset SHALL asynchronously force state=IDLE, z=0, prev_c=0, Out=0, parity=0, out_index=0, out_valid=0 and Done=0.
REQ-029 Ready SHALL be 1 while reset is asserted.
REQ-030 Reset mid-operation SHALL abort immediately with no further out_valid or Done; after release, the next start SHALL restart from PRE.

Configuration
REQ-031 Macro THETA_APPLY_EN SHALL select the Out function.
REQ-032 With THETA_APPLY_EN defined, Out[5y+x] SHALL equal In[5y+x] ^ D[x,z] (the full theta step).
REQ-033 Without THETA_APPLY_EN, Out SHALL equal In unmodified; parity, timing and handshake SHALL be identical in both builds.

Verification
REQ-034 Reset, then an all-zero state with W=64: Out=0 for z=0..63, 64 out_valid pulses, and Done coinciding with out_index=63.
REQ-035 W=64, THETA_APPLY_EN defined, only slice 0 bit 0 set: Out[z=0]=0x0210843, Out[z=1]=0x1084210, all other slices 0, and parity[z=0]=5'b00001.
REQ-036 W=64, THETA_APPLY_EN defined, only slice 63 bit 0 set (wrap check): Out[z=0]=0x1084210, Out[z=63]=0x0210843, and the PRE cycle shows page_index=63.
REQ-037 W=4, THETA_APPLY_EN undefined, random state: Out equals In per slice, parity matches the model, out_valid lasts exactly 4 cycles, and Done occurs 5 cycles after the start edge.
REQ-038 reset asserted when out_index=10, with start pulsed during RUN: out_valid drops at once, no Done occurs, and the next start gives a correct full run.
REQ-039 start held high for 3 states: three Done pulses spaced W+2 cycles apart, with the RUN-phase start ignored.

Source files
------------

// File: rtl/theta_col_parity.sv
// theta_col_parity: streams a W-slice Keccak state, one 25-bit slice per cycle, producing
// column parity per slice; THETA_APPLY_EN selects the full theta output, otherwise Out mirrors In.
module theta_col_parity #(
    parameter int W  = 64,
    parameter int IW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [24:0]   In,
    output logic [IW-1:0] page_index,
    output logic          Ready,
    output logic [24:0]   Out,
    output logic          out_valid,
    output logic [IW-1:0] out_index,
    output logic [4:0]    parity,
    output logic          Done
);

    typedef enum logic [1:0] {IDLE, PRE, RUN} state_t;

    localparam logic [IW-1:0] LAST = IW'(W - 1);

    state_t      state;
    logic [IW-1:0] z;
    logic [4:0]  col_c;
    logic [24:0] next_out;

    always_comb begin
        col_c = '0;
        for (int y = 0; y < 5; y++)
            col_c = col_c ^ In[5*y +: 5];
    end

`ifdef THETA_APPLY_EN
    // prev_c carries C of slice z-1; PRE seeds it with slice W-1 so z=0 wraps correctly.
    logic [4:0] prev_c;
    logic [4:0] d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            prev_c <= '0;
        else if (state != IDLE)
            prev_c <= col_c;
    end

    always_comb begin
        d = '0;
        for (int x = 0; x < 5; x++)
            d[x] = col_c[(x + 4) % 5] ^ prev_c[(x + 1) % 5];
        next_out = In ^ {5{d}};
    end
`else
    assign next_out = In;
`endif

    // NOTE: every output of this block gets a value on every path; the default up front
    // stops a latch being inferred for page_index.
    always_comb begin
        page_index = '0;
        case (state)
            PRE:     page_index = LAST;
            RUN:     page_index = z;
            default: page_index = '0;
        endcase
    end

    assign Ready = (state == IDLE);

    // NOTE: all state here uses non-blocking assignments so every register samples the
    // pre-edge values of its neighbours, matching real flip-flop behaviour.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            z         <= '0;
            Out       <= '0;
            parity    <= '0;
            out_index <= '0;
            out_valid <= 1'b0;
            Done      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            Done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start)
                        state <= PRE;
                end
                PRE: begin
                    z     <= '0;
                    state <= RUN;
                end
                RUN: begin
                    Out       <= next_out;
                    parity    <= col_c;
                    out_index <= z;
                    out_valid <= 1'b1;
                    z         <= z + IW'(1);
                    if (z == LAST) begin
                        Done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_theta_col_parity.sv
// Directed bench for theta_col_parity: a W=64 and a W=4 instance, each fed from a slice
// memory, compared against a small column-parity/theta model.
`timescale 1ns/1ps
module tb_theta_col_parity;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start64, start4;
    logic sel4;

    logic [24:0] mem64 [64];
    logic [24:0] mem4  [4];

    logic [5:0]  pi64, oi64;
    logic [1:0]  pi4, oi4;
    logic [24:0] in64, in4, out64, out4;
    logic [4:0]  par64, par4;
    logic        rdy64, rdy4, ov64, ov4, done64, done4;

    assign in64 = mem64[pi64];
    assign in4  = mem4[pi4];

    theta_col_parity #(.W(64), .IW(6)) u_dut64 (
        .clk(clk), .reset(reset), .start(start64), .In(in64), .page_index(pi64),
        .Ready(rdy64), .Out(out64), .out_valid(ov64), .out_index(oi64),
        .parity(par64), .Done(done64)
    );

    theta_col_parity #(.W(4), .IW(2)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .In(in4), .page_index(pi4),
        .Ready(rdy4), .Out(out4), .out_valid(ov4), .out_index(oi4),
        .parity(par4), .Done(done4)
    );

    // Selected-instance views so one run task serves both widths.
    logic [31:0] pi_m, oi_m;
    logic [24:0] out_m;
    logic [4:0]  par_m;
    logic        rdy_m, ov_m, done_m;
    assign pi_m   = sel4 ? 32'(pi4) : 32'(pi64);
    assign oi_m   = sel4 ? 32'(oi4) : 32'(oi64);
    assign out_m  = sel4 ? out4 : out64;
    assign par_m  = sel4 ? par4 : par64;
    assign rdy_m  = sel4 ? rdy4 : rdy64;
    assign ov_m   = sel4 ? ov4 : ov64;
    assign done_m = sel4 ? done4 : done64;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] colp(input logic [24:0] s);
        logic [4:0] c;
        c = '0;
        for (int y = 0; y < 5; y++)
            c = c ^ s[5*y +: 5];
        return c;
    endfunction

    function automatic logic [24:0] model_out(input logic [24:0] cur, input logic [24:0] prv);
`ifdef THETA_APPLY_EN
        logic [4:0] c;
        logic [4:0] p;
        logic [4:0] d;
        c = colp(cur);
        p = colp(prv);
        for (int x = 0; x < 5; x++)
            d[x] = c[(x + 4) % 5] ^ p[(x + 1) % 5];
        return cur ^ {5{d}};
`else
        logic [24:0] unused_prv;
        unused_prv = prv;
        return cur;
`endif
    endfunction

    function automatic logic [24:0] get_slice(input int idx);
        logic [31:0] u;
        u = 32'(idx);
        return sel4 ? mem4[u[1:0]] : mem64[u[5:0]];
    endfunction

    task automatic set_start(input logic v);
        if (sel4) start4 = v;
        else      start64 = v;
    endtask

    logic [24:0] obs     [64];
    logic [4:0]  obs_par [64];

    // One full state: start at edge 0, PRE in cycle 0, out_valid expected in cycles 2..W+1.
    task automatic run_state();
        int w;
        int nvalid;
        int ndone;
        int first;
        int done_at;
        int idx;
        logic [24:0] prv;
        w = sel4 ? 4 : 64;
        nvalid = 0; ndone = 0; first = -1; done_at = -1; idx = 0;
        @(negedge clk);
        check("idle ready", 32'(rdy_m), 32'd1);
        check("idle page_index", pi_m, 32'd0);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        check("pre page_index", pi_m, 32'(w - 1));
        check("pre ready", 32'(rdy_m), 32'd0);
        for (int c = 1; c <= w + 2; c++) begin
            @(negedge clk);
            if (ov_m) begin
                nvalid++;
                if (first < 0) first = c;
                check("out_index order", oi_m, 32'(idx));
                prv = get_slice((idx + w - 1) % w);
                check("out value", 32'(out_m), 32'(model_out(get_slice(idx), prv)));
                check("parity value", 32'(par_m), 32'(colp(get_slice(idx))));
                if (idx < 64) begin
                    obs[idx]     = out_m;
                    obs_par[idx] = par_m;
                end
                idx++;
            end
            if (done_m) begin
                ndone++;
                done_at = c;
                check("done index", oi_m, 32'(w - 1));
            end
            if (c == w + 1) check("ready after run", 32'(rdy_m), 32'd1);
        end
        check("valid count", 32'(nvalid), 32'(w));
        check("first valid cycle", 32'(first), 32'd2);
        check("done count", 32'(ndone), 32'd1);
        check("done cycle", 32'(done_at), 32'(w + 1));
        check("hold out", 32'(out_m), 32'(obs[w - 1]));
        check("hold out_index", oi_m, 32'(w - 1));
    endtask

    initial begin
        int dones [$];
        int cyc;
        int nv;
        int found;

        reset = 1'b1;
        start64 = 1'b0;
        start4 = 1'b0;
        sel4 = 1'b0;
        for (int i = 0; i < 64; i++) mem64[i] = '0;
        for (int i = 0; i < 4; i++)  mem4[i]  = '0;
        #1;
        check("rst ready", 32'(rdy64), 32'd1);
        check("rst out_valid", 32'(ov64), 32'd0);
        check("rst done", 32'(done64), 32'd0);
        check("rst out", 32'(out64), 32'd0);
        check("rst parity", 32'(par64), 32'd0);
        check("rst out_index", 32'(oi64), 32'd0);
        check("rst page_index", 32'(pi64), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // All-zero state.
        run_state();
        check("zero out z63", 32'(obs[63]), 32'd0);

        // Single bit in slice 0.
        mem64[0] = 25'h1;
        run_state();
        check("bit0 parity z0", 32'(obs_par[0]), 32'h01);
`ifdef THETA_APPLY_EN
        check("bit0 out z0", 32'(obs[0]), 32'h0210843);
        check("bit0 out z1", 32'(obs[1]), 32'h1084210);
`else
        check("bit0 out z0", 32'(obs[0]), 32'h1);
        check("bit0 out z1", 32'(obs[1]), 32'h0);
`endif
        check("bit0 out z2", 32'(obs[2]), 32'd0);
        check("bit0 out z63", 32'(obs[63]), 32'd0);

        // Single bit in slice 63: exercises the wrap into z=0.
        mem64[0] = '0;
        mem64[63] = 25'h1;
        run_state();
`ifdef THETA_APPLY_EN
        check("wrap out z0", 32'(obs[0]), 32'h1084210);
        check("wrap out z63", 32'(obs[63]), 32'h0210843);
`else
        check("wrap out z0", 32'(obs[0]), 32'h0);
        check("wrap out z63", 32'(obs[63]), 32'h1);
`endif
        check("wrap out z1", 32'(obs[1]), 32'd0);

        // Random 64-slice state.
        for (int i = 0; i < 64; i++) mem64[i] = 25'($urandom);
        run_state();

        // Random 4-slice state on the small instance.
        sel4 = 1'b1;
        for (int i = 0; i < 4; i++) mem4[i] = 25'($urandom);
        run_state();

        // start held high: three back-to-back states, W+2 cycles apart.
        @(negedge clk);
        start4 = 1'b1;
        cyc = 0;
        nv = 0;
        while (dones.size() < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (ov4) nv++;
            if (done4) begin
                dones.push_back(cyc);
                if (dones.size() == 3) start4 = 1'b0;
            end
        end
        start4 = 1'b0;
        check("b2b done count", 32'(dones.size()), 32'd3);
        if (dones.size() == 3) begin
            check("b2b gap1", 32'(dones[1] - dones[0]), 32'd6);
            check("b2b gap2", 32'(dones[2] - dones[1]), 32'd6);
        end
        check("b2b valid count", 32'(nv), 32'd12);
        nv = 0;
        repeat (8) begin
            @(negedge clk);
            if (ov4 || done4) nv++;
        end
        check("b2b no fourth run", 32'(nv), 32'd0);

        // Reset in the middle of a run, with a stray start during RUN.
        sel4 = 1'b0;
        @(negedge clk);
        start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
        found = 0;
        for (int c = 1; c < 100 && found == 0; c++) begin
            @(negedge clk);
            start64 = (c == 5);
            if (ov64 && oi64 == 6'd10) found = 1;
        end
        start64 = 1'b0;
        check("reached index 10", 32'(found), 32'd1);
        reset = 1'b1;
        #1;
        check("abort out_valid", 32'(ov64), 32'd0);
        check("abort done", 32'(done64), 32'd0);
        check("abort ready", 32'(rdy64), 32'd1);
        check("abort out", 32'(out64), 32'd0);
        check("abort out_index", 32'(oi64), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        nv = 0;
        repeat (6) begin
            @(negedge clk);
            if (ov64 || done64) nv++;
        end
        check("no activity after abort", 32'(nv), 32'd0);
        for (int i = 0; i < 64; i++) mem64[i] = 25'($urandom);
        run_state();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
